// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mult/div busy tracking, jump/branch squashing.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_md_start,
    input  logic       id_uses_hilo,
    input  logic       id_jump,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       md_accept,
    output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam logic [CNT_W-1:0] MdLoad = CNT_W'(MD_LAT);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             busy;
    logic             rs_hit, rt_hit;
    logic             lu, mdh, stall;

    always_comb begin
        busy   = (md_cnt_q != '0);
        rs_hit = id_uses_rs && (id_rs == ex_rt);
        rt_hit = id_uses_rt && (id_rt == ex_rt);
        // $0 is hardwired to zero, so a load targeting it can never feed a consumer
        lu     = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);
        mdh    = busy && (id_uses_hilo || id_md_start);
        stall  = lu || mdh;
    end

    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_accept  = 1'b0;
        md_busy    = 1'b0;
        if (!rst) begin
            md_busy = busy;
            if (ex_branch_taken) begin
                // The ID instruction is on the wrong path, so any stall it raised is moot
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall) begin
                idex_flush = 1'b1;
            end else if (id_jump) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
                md_accept  = id_md_start;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                md_accept  = id_md_start;
            end
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_accept) begin
            md_cnt_d = MdLoad;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall && !ex_branch_taken) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ifid_flush) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random stimulus,
// compared against a cycle-count based reference model.
module tb_hazard_ctrl;

    localparam int unsigned MD_LAT = 4;
    localparam int unsigned CNT_W  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_md_start, id_uses_hilo, id_jump;
    logic       ex_memread, ex_branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, md_accept, md_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    logic [31:0] stall_m, flush_m;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint busy_end = 0;

    hazard_ctrl #(
        .MD_LAT(MD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_md_start    (id_md_start),
        .id_uses_hilo   (id_uses_hilo),
        .id_jump        (id_jump),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .md_accept      (md_accept),
        .md_busy        (md_busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_md_start = 1'b0;
        id_uses_hilo = 1'b0; id_jump = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
    endtask

    // Evaluate one cycle: check outputs mid-cycle, then advance the model across the edge.
    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_flush, md_accept, md_busy}.
    task automatic step(input string tag);
        logic       lu, busy, stall;
        logic [5:0] exp;
        #1;
        if (rst) begin
            busy_end = cyc;
`ifdef HAZ_PERF_CNT_EN
            stall_m = 32'd0;
            flush_m = 32'd0;
`endif
        end
        lu    = ex_memread && ex_rt != 0 &&
                ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        busy  = !rst && (cyc < busy_end);
        stall = lu || (busy && (id_uses_hilo || id_md_start));
        if (rst)                  exp = 6'b000000;
        else if (ex_branch_taken) exp = {4'b1111, 1'b0, busy};
        else if (stall)           exp = {4'b0001, 1'b0, busy};
        else if (id_jump)         exp = {4'b1110, id_md_start, busy};
        else                      exp = {4'b1100, id_md_start, busy};
        check(tag, 32'({pc_write, ifid_write, ifid_flush, idex_flush, md_accept, md_busy}),
              32'(exp));
`ifdef HAZ_PERF_CNT_EN
        check({tag, "_stall_cnt"}, stall_cycles, stall_m);
        check({tag, "_flush_cnt"}, flush_events, flush_m);
`endif
        @(posedge clk);
        if (!rst) begin
            if (exp[1]) busy_end = cyc + 1 + MD_LAT;
`ifdef HAZ_PERF_CNT_EN
            if (stall && !ex_branch_taken) stall_m = stall_m + 32'd1;
            if (exp[3]) flush_m = flush_m + 32'd1;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
`ifdef HAZ_PERF_CNT_EN
        stall_m = 32'd0;
        flush_m = 32'd0;
`endif
        @(negedge clk);
        step("reset");
        step("reset_hold");
        rst = 1'b0;
        step("idle_default");

        // Load-use on rs, then released
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        step("lu_stall");
        ex_memread = 1'b0;
        step("lu_release");

        // A load into $0 never stalls
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        step("zero_reg");

        // Hazard through rt only; matching rs is ignored when rs is unused
        ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0; id_rt = 5'd5; id_uses_rt = 1'b1;
        step("lu_rt");
        id_uses_rt = 1'b0;
        step("rs_unused");

        // Mult/div start then dependent mfhi
        idle();
        id_md_start = 1'b1;
        step("md_start");
        id_md_start = 1'b0; id_uses_hilo = 1'b1;
        repeat (MD_LAT) step("md_hilo_stall");
        step("md_hilo_go");

        // Back-to-back starts: second one waits until idle then reloads
        idle();
        id_md_start = 1'b1;
        repeat (MD_LAT + 3) step("md_b2b");
        idle();
        repeat (MD_LAT + 1) step("md_drain");

        // Taken branch overrides a load-use stall and blocks a mult/div start
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        ex_branch_taken = 1'b1; id_md_start = 1'b1;
        step("br_over_stall");
        idle();
        step("br_no_md");

        // Jump alone, then jump held behind a load-use
        id_jump = 1'b1;
        step("jump");
        ex_memread = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        step("jump_held");

        // Reset in the middle of a busy period
        idle();
        id_md_start = 1'b1;
        step("md_start2");
        id_md_start = 1'b0;
        step("md_busy_cnt4");
        rst = 1'b1; id_uses_hilo = 1'b1;
        step("rst_mid_busy");
        rst = 1'b0;
        step("post_rst_hilo");

        // Random phase with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 63) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_memread      = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_jump         = ($urandom_range(0, 5) == 0);
            id_md_start     = ($urandom_range(0, 5) == 0);
            id_uses_hilo    = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Sequences the IF/ID register (write-enable, flush), the PC write-enable and the ID/EX bubble insertion.
- Detects load-use hazards, tracks the multi-cycle mult/div unit, and squashes wrong-path instructions on jumps (resolved in ID) and taken branches (resolved in EX).

Parameters:
MD_LAT, 32, busy cycles of the mult/div unit after an accepted start (1..63)
CNT_W, 6, width of the mult/div busy counter; must satisfy 2^CNT_W > MD_LAT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_md_start  in  1  ID instruction is mult/div (starts unit)
id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
id_jump  in  1  ID instruction is j/jal/jr (target known in ID)
ex_memread  in  1  EX instruction is a load
ex_rt  in  5  destination register of EX load
ex_branch_taken  in  1  branch in EX resolved taken
pc_write  out  1  PC register write-enable
ifid_write  out  1  IF/ID write-enable
ifid_flush  out  1  IF/ID flush (clears instr/PC to 0)
idex_flush  out  1  ID/EX bubble (clear control bits)
md_accept  out  1  mult/div start accepted this cycle
md_busy  out  1  mult/div unit busy

Behaviour:
- Outputs are combinational from registered state and inputs. Only state is md_cnt[CNT_W-1:0].
- Reset: md_cnt=0 asynchronously. While rst=1, all outputs are 0. Reset mid-operation aborts any busy period; md_busy=0 after reset.
- md_busy = (md_cnt != 0).
- Load-use hazard lu = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Mult/div hazard mdh = md_busy & (id_uses_hilo | id_md_start).
- stall = lu | mdh.
- Priority 1: ex_branch_taken=1 → pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, md_accept=0. Overrides stall and jump; a pending stall is cancelled because the ID instruction is squashed.
- Priority 2: stall=1 → pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, md_accept=0. A jump in ID is held, not acted on.
- Priority 3: id_jump=1 → pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0. The jump proceeds; only the fetched delay-slot instruction is squashed (no architectural delay slot).
- Default: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- md_accept = id_md_start & ~stall & ~ex_branch_taken & ~rst.
- md_cnt update on each rising edge:
  - if md_accept: load MD_LAT;
  - else if md_cnt!=0: decrement;
  - else: hold 0.
- Timing: start accepted at edge E0 gives md_busy high for exactly MD_LAT cycles; a dependent mfhi in ID proceeds in the cycle after md_cnt reaches 0.
- Back-to-back mult/div: the second start stalls until not busy, then is accepted and reloads the counter.
- Register $0 never creates a load-use hazard.
- lu and mdh together: single stall; load-use clears after 1 cycle, md stall persists until md_cnt=0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both asynchronously reset to 0.
  - stall_cycles increments each cycle stall=1 and ex_branch_taken=0.
  - flush_events increments each cycle ifid_flush=1.
  - Both wrap 0xFFFFFFFF→0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 → one cycle with pc_write=0, ifid_write=0, idex_flush=1. Next cycle (ex_memread=0) all defaults.
- $0 load: ex_memread=1, ex_rt=0, id_rs=0, id_uses_rs=1 → no stall, pc_write=1, idex_flush=0.
- Mult/div with MD_LAT=4: id_md_start=1 at cycle 0 → md_accept=1, md_busy=1 for cycles 1–4. id_uses_hilo=1 from cycle 1 stalls cycles 1–4 and proceeds at cycle 5.
- Branch over stall: lu=1 and ex_branch_taken=1 in the same cycle → ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. id_md_start=1 in that cycle gives md_accept=0 and md_cnt stays 0.
- Jump: id_jump=1, no hazard → ifid_flush=1, pc_write=1, idex_flush=0. Jump with lu=1 → stall outputs only, ifid_flush=0.
- Reset mid-busy: assert rst at md_cnt=3 → md_busy=0 and all outputs 0 immediately. After release, id_uses_hilo=1 gives no stall.
